// File: rtl/ram_fifo_pkg.sv
// Shared defaults and derived sizes for the RAM-backed streaming FIFO controller.
package ram_fifo_pkg;

    localparam int unsigned A_DEFAULT = 10;
    localparam int unsigned D_DEFAULT = 8;
    localparam int unsigned DEPTH     = 2 ** A_DEFAULT;
    localparam int unsigned CAP       = DEPTH + 2;
    localparam int unsigned LEVEL_W   = A_DEFAULT + 2;

    function automatic int unsigned depth_of(input int unsigned a);
        return 2 ** a;
    endfunction

endpackage

// File: rtl/ram_fifo_obuf.sv
// Two-entry registered output buffer that absorbs the one-cycle RAM read latency.
module ram_fifo_obuf
    import ram_fifo_pkg::*;
#(
    parameter int unsigned D = D_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [D-1:0] din,
    input  logic         pop,
    output logic [1:0]   count,
    output logic [D-1:0] head
);

    logic [D-1:0] head_q, head_d;
    logic [D-1:0] tail_q, tail_d;
    logic [1:0]   count_q, count_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_d = din;
                end else begin
                    tail_d = din;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // Count is unchanged; the incoming word lands behind whatever remains.
                if (count_q == 2'd1) begin
                    head_d = din;
                end else begin
                    head_d = tail_q;
                    tail_d = din;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign head  = head_q;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller in front of a single-port synchronous RAM: arbitrates one write or one
// read per cycle and re-emits stored words in order through a 2-entry output buffer.
module ram_fifo_ctrl
    import ram_fifo_pkg::*;
#(
    parameter int unsigned A = A_DEFAULT,
    parameter int unsigned D = D_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [D-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [D-1:0] out_data,
    input  logic         out_ready,
    output logic [A+1:0] level,
    output logic [A-1:0] ram_addr,
    output logic [D-1:0] ram_din,
    output logic         ram_we,
    input  logic [D-1:0] ram_dout
);

    localparam logic [A:0]   MemFull = {1'b1, {A{1'b0}}};
    localparam logic [A-1:0] PtrOne  = {{(A-1){1'b0}}, 1'b1};
    localparam logic [A:0]   CntOne  = {{A{1'b0}}, 1'b1};

    logic [A-1:0] wr_ptr_q, wr_ptr_d;
    logic [A-1:0] rd_ptr_q, rd_ptr_d;
    logic [A:0]   mem_count_q, mem_count_d;
    logic         rd_pending_q;
    logic         last_rd_q;
    logic [1:0]   ob_count;
    logic [2:0]   occ;
    logic         pop, rd_req, rd_grant, wr_en;

    assign pop = out_valid && out_ready;

    // Buffer slots already claimed by held words plus an in-flight read.
    assign occ      = {1'b0, ob_count} + {2'b00, rd_pending_q};
    assign rd_req   = (mem_count_q != '0) && (occ < (3'd2 + {2'b00, pop}));
    assign rd_grant = rd_req && !(last_rd_q && in_valid);
    assign in_ready = (mem_count_q != MemFull) && !rd_grant;
    assign wr_en    = in_valid && in_ready;

    assign ram_we   = wr_en;
    assign ram_din  = in_data;
    assign ram_addr = rd_grant ? rd_ptr_q : wr_ptr_q;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        mem_count_d = mem_count_q;
        if (wr_en) begin
            wr_ptr_d    = wr_ptr_q + PtrOne;
            mem_count_d = mem_count_q + CntOne;
        end else if (rd_grant) begin
            rd_ptr_d    = rd_ptr_q + PtrOne;
            mem_count_d = mem_count_q - CntOne;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            mem_count_q  <= '0;
            rd_pending_q <= 1'b0;
            last_rd_q    <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            mem_count_q  <= mem_count_d;
            rd_pending_q <= rd_grant;
            last_rd_q    <= rd_grant;
        end
    end

    ram_fifo_obuf #(
        .D(D)
    ) u_obuf (
        .clk  (clk),
        .rst_n(rst_n),
        .push (rd_pending_q),
        .din  (ram_dout),
        .pop  (pop),
        .count(ob_count),
        .head (out_data)
    );

    assign out_valid = (ob_count != 2'd0);
    assign level     = {1'b0, mem_count_q} + {{(A+1){1'b0}}, rd_pending_q}
                     + {{A{1'b0}}, ob_count};

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl with A=2 and a behavioural synchronous RAM; a queue scoreboard
// checks output order while per-scenario tasks check timing and boundary behaviour.
module tb_ram_fifo_ctrl;

    localparam int unsigned TA = 2;
    localparam int unsigned TD = 8;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic [TD-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [TD-1:0] out_data;
    logic          out_ready;
    logic [TA+1:0] level;
    logic [TA-1:0] ram_addr;
    logic [TD-1:0] ram_din;
    logic          ram_we;
    logic [TD-1:0] ram_dout;

    logic [TD-1:0] ram_mem [4];

    int            total = 0;
    int            bad = 0;
    int            pop_count = 0;
    int            wr_cnt = 0;
    logic [TD-1:0] last_pop = '0;
    logic [TD-1:0] stall_data = '0;
    bit            stall_prev = 0;
    logic [TD-1:0] exp_q[$];

    ram_fifo_ctrl #(
        .A(TA),
        .D(TD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .level    (level),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_we   (ram_we),
        .ram_dout (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_din;
        ram_dout <= ram_mem[ram_addr];
    end

    // Scoreboard and per-cycle invariants, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            wr_cnt = 0;
            stall_prev = 0;
        end else begin
            if (in_valid && in_ready) begin
                exp_q.push_back(in_data);
                wr_cnt++;
            end
            if (stall_prev) begin
                total++;
                if (out_valid !== 1'b1 || out_data !== stall_data) begin
                    bad++;
                    $display("FAIL stall_hold: got valid=%b data=%0h want valid=1 data=%0h",
                             out_valid, out_data, stall_data);
                end
            end
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL scoreboard_order: got %0h want nothing (queue empty)",
                             out_data);
                end else begin
                    logic [TD-1:0] e;
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        bad++;
                        $display("FAIL scoreboard_order: got %0h want %0h", out_data, e);
                    end
                end
                pop_count++;
                last_pop = out_data;
            end
            total++;
            if (dut.ob_count > 2'd2) begin
                bad++;
                $display("FAIL ob_count_max: got %0d want <=2", dut.ob_count);
            end
            stall_prev = out_valid && !out_ready;
            stall_data = out_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int bound, output bit ok);
        ok = 0;
        for (int c = 0; c < bound; c++) begin
            if (level == '0 && !out_valid) begin
                ok = 1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || level !== 4'd0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_state: got valid=%b level=%0d ready=%b want 0 0 1",
                     out_valid, level, in_ready);
        end
        in_valid = 1'b1;
        #1;
        total++;
        if (ram_we !== 1'b1) begin
            bad++;
            $display("FAIL reset_we_follows: got %b want 1", ram_we);
        end
        in_valid = 1'b0;
        #1;
        total++;
        if (ram_we !== 1'b0) begin
            bad++;
            $display("FAIL reset_we_idle: got %b want 0", ram_we);
        end
        tick();
    endtask

    task automatic test_single();
        bit ok;
        in_valid = 1'b1;
        in_data = 8'hA5;
        out_ready = 1'b1;
        #1;
        total++;
        if (ram_we !== 1'b1 || ram_addr !== 2'd0) begin
            bad++;
            $display("FAIL single_write: got we=%b addr=%0d want 1 0", ram_we, ram_addr);
        end
        tick();
        in_valid = 1'b0;
        total++;
        if (level !== 4'd1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_n: got level=%0d valid=%b want 1 0", level, out_valid);
        end
        tick();
        total++;
        if (level !== 4'd1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_n1: got level=%0d valid=%b want 1 0", level, out_valid);
        end
        tick();
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5 || level !== 4'd1) begin
            bad++;
            $display("FAIL single_n2: got valid=%b data=%0h level=%0d want 1 a5 1",
                     out_valid, out_data, level);
        end
        tick();
        total++;
        if (level !== 4'd0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_popped: got level=%0d valid=%b want 0 0", level, out_valid);
        end
        drain(10, ok);
    endtask

    task automatic test_full();
        int  k = 1;
        int  acc = 0;
        int  p0;
        bit  a;
        bit  seen_ready = 0;
        bit  ok;
        out_ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            in_valid = (k <= 8);
            in_data = 8'(k);
            #1;
            a = in_valid && in_ready;
            tick();
            if (a) begin
                k++;
                acc++;
            end
        end
        in_valid = 1'b1;
        in_data = 8'(k);
        #1;
        total++;
        if (acc != 6 || in_ready !== 1'b0 || level !== 4'd6) begin
            bad++;
            $display("FAIL full_cap: got acc=%0d ready=%b level=%0d want 6 0 6",
                     acc, in_ready, level);
        end
        p0 = pop_count;
        out_ready = 1'b1;
        for (int c = 0; c < 60; c++) begin
            in_valid = (k <= 8);
            in_data = 8'(k);
            #1;
            a = in_valid && in_ready;
            if (a) seen_ready = 1;
            tick();
            if (a) k++;
            if (k > 8 && level == '0) break;
        end
        in_valid = 1'b0;
        drain(20, ok);
        total++;
        if (!seen_ready || k != 9 || (pop_count - p0) != 8 || !ok) begin
            bad++;
            $display("FAIL full_drain: got ready_seen=%b k=%0d pops=%0d empty=%b want 1 9 8 1",
                     seen_ready, k, pop_count - p0, ok);
        end
    endtask

    task automatic test_stream();
        int i = 0;
        int cyc = 0;
        int p0 = pop_count;
        int addr_bad = 0;
        bit a;
        bit ok;
        out_ready = 1'b1;
        in_valid = 1'b1;
        while (i < 20 && cyc < 200) begin
            in_data = 8'(i);
            #1;
            a = in_ready;
            if (a && ram_addr !== 2'(wr_cnt % 4)) addr_bad++;
            tick();
            if (a) i++;
            cyc++;
        end
        in_valid = 1'b0;
        total++;
        if (addr_bad != 0) begin
            bad++;
            $display("FAIL stream_wr_addr: got %0d wrong addresses want 0", addr_bad);
        end
        total++;
        if (cyc != 39) begin
            bad++;
            $display("FAIL stream_alternate: got %0d cycles want 39", cyc);
        end
        drain(20, ok);
        total++;
        if ((pop_count - p0) != 20 || !ok) begin
            bad++;
            $display("FAIL stream_count: got pops=%0d empty=%b want 20 1", pop_count - p0, ok);
        end
    endtask

    task automatic test_toggle();
        int i = 0;
        int c = 0;
        int p0 = pop_count;
        bit a;
        while ((i < 10 || level != '0) && c < 300) begin
            out_ready = c[0];
            in_valid = (i < 10);
            in_data = 8'(100 + i);
            #1;
            a = in_valid && in_ready;
            tick();
            if (a) i++;
            c++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        total++;
        if (i != 10 || (pop_count - p0) != 10 || level !== 4'd0) begin
            bad++;
            $display("FAIL toggle_burst: got sent=%0d pops=%0d level=%0d want 10 10 0",
                     i, pop_count - p0, level);
        end
    endtask

    task automatic test_reset_mid();
        int k = 0;
        int p0;
        bit ok;
        out_ready = 1'b0;
        for (int c = 0; c < 40 && level != 4'd6; c++) begin
            in_valid = 1'b1;
            in_data = 8'(8'h50 + k);
            #1;
            if (in_ready) k++;
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++;
        if (level !== 4'd5) begin
            bad++;
            $display("FAIL midreset_pre_level: got %0d want 5", level);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        total++;
        if (level !== 4'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL midreset_clear: got level=%0d valid=%b ready=%b want 0 0 1",
                     level, out_valid, in_ready);
        end
        p0 = pop_count;
        in_valid = 1'b1;
        in_data = 8'h3C;
        out_ready = 1'b1;
        #1;
        total++;
        if (ram_we !== 1'b1 || ram_addr !== 2'd0) begin
            bad++;
            $display("FAIL midreset_write: got we=%b addr=%0d want 1 0", ram_we, ram_addr);
        end
        tick();
        in_valid = 1'b0;
        drain(20, ok);
        total++;
        if ((pop_count - p0) != 1 || last_pop !== 8'h3C || !ok) begin
            bad++;
            $display("FAIL midreset_fresh: got pops=%0d data=%0h want 1 3c",
                     pop_count - p0, last_pop);
        end
    endtask

    task automatic test_idle();
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            total++;
            if (ram_we !== 1'b0 || out_valid !== 1'b0 || level !== 4'd0) begin
                bad++;
                $display("FAIL idle_cycle%0d: got we=%b valid=%b level=%0d want 0 0 0",
                         c, ram_we, out_valid, level);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_stream();
        test_toggle();
        test_reset_mid();
        test_idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ram_fifo_ctrl.md
# ram_fifo_ctrl

Streaming FIFO controller that sits directly upstream of the single-port synchronous RAM (`Ram_sync`, one access per cycle, registered read data one cycle after the address). It accepts a valid/ready input stream, and arbitrates each cycle between one RAM write and one RAM read. It re-emits the stored words in order on a valid/ready output stream through a 2-entry output buffer that absorbs the RAM read latency. Total capacity is 2^A + 2 words.

## Interface
- `A`, 10, RAM address bits; RAM depth 2^A.
- `D`, 8, data bits.

- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `in_valid` in 1: upstream word present.
- `in_data` in D: upstream word.
- `in_ready` out 1: word accepted on an edge where `in_valid && in_ready`.
- `out_valid` out 1: output buffer head valid.
- `out_data` out D: output buffer head.
- `out_ready` in 1: downstream consumes on an edge where `out_valid && out_ready`.
- `level` out A+2: total words held (RAM + in-flight read + output buffer), range 0..2^A+2.
- `ram_addr` out A: to RAM `addr`.
- `ram_din` out D: to RAM `din`; always equals `in_data`.
- `ram_we` out 1: to RAM `we`.
- `ram_dout` in D: from RAM `dout`.

## Operation
- State:
  - `wr_ptr` and `rd_ptr` (A bits each, wrap modulo 2^A).
  - `mem_count` (A+1 bits, 0..2^A, count of words written but not yet read).
  - `rd_pending` (1 bit, a read issued on the previous edge).
  - `last_rd` (1 bit).
  - Output buffer: 2 entries, `ob_count` 0..2.
- Read request: `rd_req = (mem_count != 0) && (ob_count + rd_pending - pop < 2)`. Here `pop = out_valid && out_ready`.
- Read grant: `rd_grant = rd_req && !(last_rd && in_valid)`.
  - Reads win unless the previous cycle was a read and a write is waiting.
  - Under simultaneous streaming, reads and writes alternate, giving 1 word per 2 cycles.
- `in_ready = (mem_count != 2^A) && !rd_grant`. `ram_we = in_valid && in_ready`.
- `ram_addr = rd_grant ? rd_ptr : wr_ptr`.
- On write: `wr_ptr+1`, `mem_count+1`. On read grant: `rd_ptr+1`, `mem_count-1`, `rd_pending` set next cycle. Write and read grant are mutually exclusive.
- When `rd_pending` is set: push `ram_dout` into the output buffer on that edge.
  - A push and a pop on the same edge leave `ob_count` unchanged, with data order preserved.
  - The buffer never overflows, because `rd_req` reserves the slot in advance.
- `out_valid = ob_count != 0`. `out_data` is the oldest entry; it is registered and holds stable while `out_valid && !out_ready`.
- `level = mem_count + rd_pending + ob_count`.
- No read-after-write hazard: a word becomes readable only on the edge after its write, so the RAM returns the new data.
- RAM contents are never cleared. Reset discards all buffered words.

## Timing
- Reset (`rst_n == 0` at an edge) sets: pointers 0, `mem_count` 0, `rd_pending` 0, `last_rd` 0, `ob_count` 0.
  - As a result `out_valid`=0, `level`=0, `in_ready`=1 and `ram_we` follows `in_valid` in the first cycle after reset.
  - Reset mid-operation drops everything, including an in-flight read. Its `ram_dout` is ignored.
- Latency when empty with no contention:
  - Accept at edge N → read issued in cycle N..N+1 → `rd_pending` after N+1 → `out_valid`=1 after edge N+2.
- Full (`mem_count == 2^A`): `in_ready`=0 regardless of reads.
  - With `out_ready`=0, exactly 2^A+2 words are accepted before `in_ready` stays low.
- Pointers wrap from 2^A−1 to 0 without a bubble.
- `in_ready` may depend combinationally on `in_valid` and `out_ready`. `out_valid` is purely registered.

## Structure
- Package `ram_fifo_pkg`: default A/D and the derived localparams DEPTH=2^A, CAP=2^A+2, LEVEL_W=A+2. There is no FSM enum; arbitration is the single `last_rd` flag.
- One sub-module: `ram_fifo_obuf`, the 2-entry registered output buffer with push/pop, `count` and head outputs.
- The RAM stays outside this block. The top level wires `ram_*` to a `Ram_sync` instance with matching A/D.

## Test plan
- Reset, then a single word 0xA5 at edge N with `out_ready`=1 → `ram_we`=1, `ram_addr`=0 at N. `out_valid`=1 with `out_data`=0xA5 after N+2. `level` 1→0 after the pop.
- A=2, `out_ready`=0, `in_valid` held with data 1..8 → 6 accepted and `in_ready` low thereafter, `level`=6.
  - Then `out_ready`=1 → outputs 1..6 in order, and `in_ready` returns once `mem_count`<4.
- Continuous in/out streaming, A=2, 20 words 0..19 → reads and writes alternate. The output is 0..19 in order with no loss, and pointers wrap at least 4 times.
- `out_ready` toggling 1/0 each cycle during a 10-word burst → `out_data` stable while stalled, no duplicates, `ob_count` never exceeds 2.
- `rst_n`=0 for one edge while a read is in flight and `level`=5 → everything cleared after that edge. A new word 0x3C written next → output 0x3C, not stale data.
- Empty FIFO with `out_ready`=1 and `in_valid`=0 for 10 cycles → `ram_we`=0, `out_valid`=0, `level`=0 throughout.
